// File: rtl/calc_key_engine.sv
// Calculator key engine: builds hex operands from key strobes, applies the latched
// operator on EXE and holds the result for the display path.
module calc_key_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    output logic [WIDTH-1:0] display,
    output logic [4:0]       cur_op,
    output logic [1:0]       state,
    output logic             result_valid,
    output logic             overflow,
    output logic             key_ignored
);

    localparam int MAX_DIGITS = WIDTH / 4;
    localparam int CW         = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    localparam logic [4:0] K_ADD  = 5'h10;
    localparam logic [4:0] K_MUL  = 5'h11;
    localparam logic [4:0] K_AND  = 5'h12;
    localparam logic [4:0] K_EXE  = 5'h13;
    localparam logic [4:0] K_SUB  = 5'h14;
    localparam logic [4:0] K_OR   = 5'h15;
    localparam logic [4:0] K_CE   = 5'h16;
    localparam logic [4:0] K_CLR  = 5'h17;
    localparam logic [4:0] OP_NONE = 5'h1F;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opnd_a, opnd_b, result;
    logic [CW-1:0]    cnt_a, cnt_b;

    logic is_digit, is_op, is_invalid, do_clear;
    logic [WIDTH-1:0] digit_ext;

    assign is_digit   = ~key_code[4];
    assign is_invalid = (key_code[4:3] == 2'b11);
    assign is_op      = (key_code == K_ADD) || (key_code == K_MUL) || (key_code == K_AND) ||
                        (key_code == K_SUB) || (key_code == K_OR);
    // CE in the result state behaves exactly like CLR.
    assign do_clear   = (key_code == K_CLR) || (state_q == S_RES && key_code == K_CE);
    assign digit_ext  = {{(WIDTH-4){1'b0}}, key_code[3:0]};

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ov;

    assign sum  = {1'b0, opnd_a} + {1'b0, opnd_b};
    assign diff = {1'b0, opnd_a} - {1'b0, opnd_b};
    assign prod = {{WIDTH{1'b0}}, opnd_a} * {{WIDTH{1'b0}}, opnd_b};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (cur_op)
            K_ADD: begin alu_res = sum[WIDTH-1:0];  alu_ov = sum[WIDTH];  end
            K_SUB: begin alu_res = diff[WIDTH-1:0]; alu_ov = diff[WIDTH]; end
            K_MUL: begin alu_res = prod[WIDTH-1:0]; alu_ov = |prod[2*WIDTH-1:WIDTH]; end
            K_AND: alu_res = opnd_a & opnd_b;
            K_OR:  alu_res = opnd_a | opnd_b;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every update lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_A;
            opnd_a      <= '0;
            opnd_b      <= '0;
            result      <= '0;
            cnt_a       <= '0;
            cnt_b       <= '0;
            cur_op      <= OP_NONE;
            overflow    <= 1'b0;
            key_ignored <= 1'b0;
        end else begin
            key_ignored <= 1'b0;
            if (key_valid) begin
                if (is_invalid) begin
                    key_ignored <= 1'b1;
                end else if (do_clear) begin
                    state_q  <= S_A;
                    opnd_a   <= '0;
                    opnd_b   <= '0;
                    result   <= '0;
                    cnt_a    <= '0;
                    cnt_b    <= '0;
                    cur_op   <= OP_NONE;
                    overflow <= 1'b0;
                end else begin
                    case (state_q)
                        S_A: begin
                            if (is_digit) begin
                                if (cnt_a == MAX_CNT) begin
                                    key_ignored <= 1'b1;
                                end else begin
                                    opnd_a <= {opnd_a[WIDTH-5:0], key_code[3:0]};
                                    cnt_a  <= cnt_a + CW'(1);
                                end
                            end else if (is_op) begin
                                cur_op  <= key_code;
                                opnd_b  <= '0;
                                cnt_b   <= '0;
                                state_q <= S_B;
                            end else if (key_code == K_EXE) begin
                                key_ignored <= 1'b1;
                            end else begin
                                opnd_a <= '0;
                                cnt_a  <= '0;
                            end
                        end
                        S_B: begin
                            if (is_digit) begin
                                if (cnt_b == MAX_CNT) begin
                                    key_ignored <= 1'b1;
                                end else begin
                                    opnd_b <= {opnd_b[WIDTH-5:0], key_code[3:0]};
                                    cnt_b  <= cnt_b + CW'(1);
                                end
                            end else if (is_op) begin
                                cur_op <= key_code;
                            end else if (key_code == K_EXE) begin
                                result   <= alu_res;
                                overflow <= alu_ov;
                                state_q  <= S_RES;
                            end else begin
                                opnd_b <= '0;
                                cnt_b  <= '0;
                            end
                        end
                        S_RES: begin
                            if (is_digit) begin
                                opnd_a   <= digit_ext;
                                cnt_a    <= CW'(1);
                                cur_op   <= OP_NONE;
                                overflow <= 1'b0;
                                state_q  <= S_A;
                            end else if (is_op) begin
                                opnd_a   <= result;
                                cnt_a    <= MAX_CNT;
                                cur_op   <= key_code;
                                opnd_b   <= '0;
                                cnt_b    <= '0;
                                overflow <= 1'b0;
                                state_q  <= S_B;
                            end else begin
                                key_ignored <= 1'b1;
                            end
                        end
                        default: state_q <= S_A;
                    endcase
                end
            end
        end
    end

    always_comb begin
        case (state_q)
            S_B:     display = (cnt_b != '0) ? opnd_b : opnd_a;
            S_RES:   display = result;
            default: display = opnd_a;
        endcase
    end

    assign state        = state_q;
    assign result_valid = (state_q == S_RES);

endmodule

// File: tb/tb_calc_key_engine.sv
// Self-checking bench for calc_key_engine: directed calculator sessions plus random
// key streams compared against an arithmetic reference model of the calculator.
module tb_calc_key_engine;

    localparam int W    = 16;
    localparam int MAXD = W / 4;
    localparam int MOD  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [4:0]   key_code = 5'h0;
    logic [W-1:0] display;
    logic [4:0]   cur_op;
    logic [1:0]   state;
    logic         result_valid, overflow, key_ignored;

    calc_key_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .display(display), .cur_op(cur_op), .state(state),
        .result_valid(result_valid), .overflow(overflow), .key_ignored(key_ignored)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: calculator held as plain integers.
    int unsigned m_a, m_b, m_res, m_ca, m_cb, m_op, m_st;
    bit m_ov, m_ign;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_res = 0; m_ca = 0; m_cb = 0;
        m_op = 'h1F; m_st = 0; m_ov = 0; m_ign = 0;
    endtask

    function automatic bit is_operator(input int unsigned k);
        return k == 'h10 || k == 'h11 || k == 'h12 || k == 'h14 || k == 'h15;
    endfunction

    task automatic model_exe();
        longint unsigned p;
        case (m_op)
            'h10: begin p = longint'(m_a) + m_b; m_res = int'(p % MOD); m_ov = (p >= MOD); end
            'h14: begin m_res = (m_a + MOD - m_b) % MOD; m_ov = (m_a < m_b); end
            'h11: begin p = longint'(m_a) * m_b; m_res = int'(p % MOD); m_ov = (p >= MOD); end
            'h12: begin m_res = m_a & m_b; m_ov = 0; end
            default: begin m_res = m_a | m_b; m_ov = 0; end
        endcase
    endtask

    task automatic model_key(input int unsigned k);
        m_ign = 0;
        if (k >= 'h18) m_ign = 1;
        else if (k == 'h17 || (m_st == 2 && k == 'h16)) model_reset();
        else if (k < 16) begin
            if (m_st == 2) begin
                m_a = k; m_ca = 1; m_op = 'h1F; m_st = 0; m_ov = 0;
            end else if (m_st == 0) begin
                if (m_ca == MAXD) m_ign = 1;
                else begin m_a = (m_a * 16 + k) % MOD; m_ca++; end
            end else begin
                if (m_cb == MAXD) m_ign = 1;
                else begin m_b = (m_b * 16 + k) % MOD; m_cb++; end
            end
        end else if (is_operator(k)) begin
            if (m_st == 2) begin m_a = m_res; m_ca = MAXD; m_ov = 0; end
            if (m_st != 1) begin m_b = 0; m_cb = 0; end
            m_op = k; m_st = 1;
        end else if (k == 'h13) begin
            if (m_st == 1) begin model_exe(); m_st = 2; end
            else m_ign = 1;
        end else begin
            if (m_st == 0) begin m_a = 0; m_ca = 0; end
            else begin m_b = 0; m_cb = 0; end
        end
    endtask

    function automatic int unsigned exp_display();
        if (m_st == 2) return m_res;
        if (m_st == 1 && m_cb > 0) return m_b;
        return m_a;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".disp"}, 32'(display), exp_display());
        check({tag, ".op"}, 32'(cur_op), m_op);
        check({tag, ".st"}, 32'(state), m_st);
        check({tag, ".rv"}, 32'(result_valid), 32'(m_st == 2));
        check({tag, ".ov"}, 32'(overflow), 32'(m_ov));
        check({tag, ".ign"}, 32'(key_ignored), 32'(m_ign));
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        model_key(k);
        check_all($sformatf("key%02h", k));
    endtask

    task automatic idle();
        @(negedge clk);
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        m_ign = 0;
        check_all("idle");
    endtask

    typedef logic [4:0] kq_t[$];
    task automatic run_seq(input kq_t q);
        foreach (q[i]) press(q[i]);
        idle();
    endtask

    // Async reset asserted between strobes; outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        key_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    localparam logic [4:0] ADD = 5'h10, MUL = 5'h11, AND_ = 5'h12, EXE = 5'h13,
                           SUB = 5'h14, OR_ = 5'h15, CE = 5'h16, CLR = 5'h17;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ops[5];
        ops = '{ADD, MUL, AND_, SUB, OR_};
        model_reset();
        rst = 1'b1;
        #12 rst = 1'b0;
        #1 check_all("reset");

        // 1: basic addition
        run_seq('{5'h1, 5'h2, ADD, 5'h3, 5'h4, EXE});
        check("t1.disp", 32'(display), 32'h0046);
        check("t1.rv", 32'(result_valid), 1);
        // 4: chaining then a new digit
        run_seq('{MUL, 5'h2, EXE});
        check("t4.disp", 32'(display), 32'h008C);
        run_seq('{5'h7});
        check("t4.op", 32'(cur_op), 32'h1F);
        check("t4.disp7", 32'(display), 32'h0007);
        // 2: digit limit
        run_seq('{CLR, 5'h1, 5'h2, 5'h3, 5'h4});
        press(5'h5);
        check("t2.ign5", 32'(key_ignored), 1);
        check("t2.disp", 32'(display), 32'h1234);
        idle();
        // 3: overflow corners
        run_seq('{CLR, 5'hF, 5'hF, 5'hF, 5'hF, ADD, 5'h1, EXE});
        check("t3.add", {31'(display), overflow}, {31'h0000, 1'b1});
        run_seq('{CLR, 5'h2, SUB, 5'h3, EXE});
        check("t3.sub", {31'(display), overflow}, {31'hFFFF, 1'b1});
        run_seq('{CLR, 5'h1, 5'h0, 5'h0, MUL, 5'h1, 5'h0, 5'h0, EXE});
        check("t3.mul", {31'(display), overflow}, {31'h0000, 1'b1});
        run_seq('{CLR, 5'hF, 5'h0, AND_, 5'h3, 5'hC, EXE});
        check("t3.and", {31'(display), overflow}, {31'h0030, 1'b0});
        // 5: CE in B, ignored keys
        run_seq('{CLR, 5'h5, ADD, 5'h9, CE, 5'h2, EXE});
        check("t5.disp", 32'(display), 32'h0007);
        run_seq('{CLR, 5'h3, EXE, 5'h1F});
        check("t5.disp3", 32'(display), 32'h0003);
        // 6: reset mid-entry, mid-EXE, and CLR from result
        run_seq('{5'h4, ADD, 5'h6});
        async_reset();
        run_seq('{5'h9, OR_, 5'h6});
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = EXE;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        model_reset();
        check_all("rst_exe");
        #3 rst = 1'b0;
        run_seq('{5'h8, SUB, 5'h1, EXE, CLR});
        check("t6.disp", 32'(display), 0);
        check("t6.op", 32'(cur_op), 32'h1F);

        // Random key streams
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 45)      press(5'($urandom_range(0, 15)));
            else if (r < 63) press(ops[$urandom_range(0, 4)]);
            else if (r < 75) press(EXE);
            else if (r < 80) press(CE);
            else if (r < 82) press(CLR);
            else if (r < 86) press(5'($urandom_range(24, 31)));
            else if (r < 93) idle();
            else if (r < 94) async_reset();
            else             press(5'($urandom_range(0, 15)));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
